trace_issuer: RTL
=================

TRACE_ISSUER -- requirements
Module: trace_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning trace FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter GAP, default 0, meaning NOP cycles inserted after each issued access.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that leaves IDLE.
REQ-006 SHALL have port pause  input  1  holds issue (NOP driven) while high.
REQ-007 SHALL have port in_valid  input  1  trace entry offered.
REQ-008 SHALL have port in_ready  output  1  entry accepted when in_valid && in_ready at posedge.
REQ-009 SHALL have port in_type  input  2  access type: 0 read, 1 write, 2 invalidate.
REQ-010 SHALL have port in_addr  input  32  requested byte address.
REQ-011 SHALL have port in_last  input  1  marks final trace entry.
REQ-012 SHALL have port Access_type  output  2  registered access type to cache; 3 = NOP, ignored by cache.
REQ-013 SHALL have port Hex_address  output  32  registered address to cache.
REQ-014 SHALL have port done  output  1  high once last entry issued.

Function
REQ-015 SHALL buffer accepted entries {type, addr, last} in FIFO order; in_ready = !full && state != DONE.
REQ-016 SHALL drop (accept, not store) entries with in_type == 3.
REQ-017 SHALL implement states IDLE, RUN, WAIT, DONE; IDLE->RUN on start; start ignored outside IDLE.
REQ-018 SHALL accept entries in IDLE and RUN/WAIT; issue only in RUN.
REQ-019 In RUN with FIFO non-empty and pause low, SHALL pop head and register Access_type/Hex_address from it; otherwise drive Access_type=3, Hex_address=0.
REQ-020 SHALL issue at most one access per cycle; entry accepted at edge t is earliest on outputs after edge t+1.
REQ-021 After an issue with GAP>0, SHALL go to WAIT and drive NOP for exactly GAP cycles, then return to RUN; GAP=0 allows back-to-back issue.
REQ-022 pause SHALL not alter the WAIT count; WAIT->RUN occurs irrespective of pause.
REQ-023 Issuing an entry with last=1 SHALL go to DONE (after GAP if nonzero is NOT applied); done=1 from the following cycle until rst.
REQ-024 In DONE SHALL drive NOP and accept nothing; any remaining FIFO entries are discarded.
REQ-025 Full FIFO SHALL deassert in_ready; simultaneous pop frees space only from the next cycle.

Reset
REQ-026 rst SHALL set state IDLE, empty FIFO, Access_type=3, Hex_address=0, done=0, in_ready=1, counters 0.
REQ-027 rst mid-operation SHALL discard all buffered entries and the pending WAIT count.

Configuration
REQ-028 With TRACE_ISSUER_STATS_EN defined, SHALL add outputs issued_reads, issued_writes, issued_invalidates (32-bit, saturating), incremented on the issue edge.
REQ-029 Without TRACE_ISSUER_STATS_EN, those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-030 Package cache_pkg SHALL hold access_t enum (READ=0, WRITE=1, INVALIDATE=2, NOP=3) and trace entry struct.
REQ-031 FIFO SHALL be sub-module trace_fifo (parameter DEPTH, push/pop/full/empty).

Verification
REQ-032 Reset, start, push read 0x0000_1040 -> Access_type=0, Hex_address=0x0000_1040 two edges after push, then NOP.
REQ-033 GAP=2, push write 0x10, write 0x20 -> issues separated by exactly 2 NOP cycles.
REQ-034 Push DEPTH entries with start low -> in_ready=0 after DEPTH-th; start -> entries issued in order.
REQ-035 Push type 3 then invalidate 0x80 (last=1) -> only invalidate issued; done=1 next cycle; in_ready=0.
REQ-036 pause high 3 cycles mid-stream -> 3 NOPs, no entry lost; rst mid-stream -> outputs NOP, done=0, FIFO empty.
REQ-037 With TRACE_ISSUER_STATS_EN, issue 2 reads, 1 write, 1 invalidate -> counters 2/1/1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the trace issuer: cache access encoding, buffered trace entry
// and a saturating counter helper.
package cache_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2,
        NOP        = 2'd3
    } access_t;

    typedef struct packed {
        access_t     acc;
        logic [31:0] addr;
        logic        last;
    } trace_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Power-of-two FIFO of trace entries; pointers carry one wrap bit to tell full
// from empty. flush empties it synchronously.
module trace_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  trace_entry_t din,
    input  logic         pop,
    output trace_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    trace_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    // Read/write pointer update
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage array; contents are meaningless while empty so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/trace_issuer.sv
// Replays a buffered trace of cache accesses, one per cycle with optional NOP gap.
// Define TRACE_ISSUER_STATS_EN to add saturating per-type issue counters.
module trace_issuer
    import cache_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [31:0] in_addr,
    input  logic        in_last,
    output logic [1:0]  Access_type,
    output logic [31:0] Hex_address,
    output logic        done
`ifdef TRACE_ISSUER_STATS_EN
    ,
    output logic [31:0] issued_reads,
    output logic [31:0] issued_writes,
    output logic [31:0] issued_invalidates
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int            GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_L = GW'(GAP);
    localparam logic [GW-1:0] ONE_L = GW'(1);

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] wait_q, wait_d;
    access_t       acc_q, acc_d;
    logic [31:0]   addr_q, addr_d;
    logic          done_q, done_d;

    trace_entry_t  head_s;
    trace_entry_t  din_s;
    logic          full_s, empty_s, push_s, issue_s, flush_s;

    assign in_ready = !full_s && (state_q != S_DONE);
    // Type 3 entries are handshaken but never stored
    assign push_s   = in_valid && in_ready && (in_type != 2'd3);
    assign issue_s  = (state_q == S_RUN) && !empty_s && !pause;
    assign flush_s  = (state_q == S_DONE);
    assign din_s    = '{acc: access_t'(in_type), addr: in_addr, last: in_last};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (push_s),
        .din   (din_s),
        .pop   (issue_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next-state and output selection
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        acc_d   = NOP;
        addr_d  = 32'd0;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (issue_s) begin
                    acc_d  = head_s.acc;
                    addr_d = head_s.addr;
                    if (head_s.last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = S_WAIT;
                        wait_d  = GAP_L;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_WAIT: begin
                if (wait_q <= ONE_L) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q - ONE_L;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered cache-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            acc_q   <= NOP;
            addr_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign Access_type = acc_q;
    assign Hex_address = addr_q;
    assign done        = done_q;

`ifdef TRACE_ISSUER_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, inv_cnt_q;

    // Per-type issue counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            inv_cnt_q <= 32'd0;
        end else if (issue_s) begin
            case (head_s.acc)
                READ:       rd_cnt_q  <= sat_inc(rd_cnt_q);
                WRITE:      wr_cnt_q  <= sat_inc(wr_cnt_q);
                INVALIDATE: inv_cnt_q <= sat_inc(inv_cnt_q);
                default:    rd_cnt_q  <= rd_cnt_q;
            endcase
        end else begin
            rd_cnt_q <= rd_cnt_q;
        end
    end

    assign issued_reads       = rd_cnt_q;
    assign issued_writes      = wr_cnt_q;
    assign issued_invalidates = inv_cnt_q;
`endif

endmodule
